// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first payload, optional even/odd parity, stop bit.
// One serial bit per CLK cycle; TX_OUT and busy come straight from flops.
module uart_tx_framer #(
    parameter int unsigned data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [data_width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int unsigned cnt_width = $clog2(data_width + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [cnt_width-1:0]  bit_cnt;
    logic [data_width-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;

    logic [cnt_width-1:0]  next_idx;
    logic                  next_bit;
    logic                  last_bit;
    logic                  parity_bit;

    // bit_cnt holds the index of the data bit currently on the line.
    always_comb begin
        next_idx   = bit_cnt + cnt_width'(1);
        last_bit   = (bit_cnt == cnt_width'(data_width - 1));
        parity_bit = (^data_reg) ^ par_typ_reg;
        next_bit   = 1'b1;
        for (int unsigned i = 0; i < data_width; i++) begin
            if (next_idx == cnt_width'(i)) begin
                next_bit = data_reg[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            TX_OUT      <= 1'b1;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        data_reg    <= P_DATA;
                        par_en_reg  <= PAR_EN;
                        par_typ_reg <= PAR_TYP;
                        state       <= START;
                        TX_OUT      <= 1'b0;
                        busy        <= 1'b1;
                    end else begin
                        TX_OUT <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    TX_OUT  <= data_reg[0];
                end
                DATA: begin
                    if (last_bit) begin
                        if (par_en_reg) begin
                            state  <= PARITY;
                            TX_OUT <= parity_bit;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= next_idx;
                        TX_OUT  <= next_bit;
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                end
                STOP: begin
                    // Requests seen here are dropped; the next one needs an IDLE cycle.
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: directed frames, request masking, back-to-back,
// mid-frame reset and randomized frames against a bit-list reference model.
module tb_uart_tx_framer;

    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          busy;

    int   n_checks = 0;
    int   n_passed = 0;
    logic exp_q[$];

    uart_tx_framer #(.data_width(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Expected line levels for one frame, one entry per busy cycle.
    task automatic build_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        int ones;
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe) exp_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
        exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        RST = 1'b0; Data_Valid = 1'b1; P_DATA = DW'($urandom); PAR_EN = 1'b1; PAR_TYP = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== 1'b1) $display("FAIL reset_tx: TX_OUT=%b expected 1", TX_OUT);
            else n_passed++;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b expected 0", busy);
            else n_passed++;
        end
        RST = 1'b1; Data_Valid = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0)
                $display("FAIL reset_idle: TX_OUT=%b busy=%b expected 1 0", TX_OUT, busy);
            else n_passed++;
        end
    endtask

    // Starts and ends at a negedge with Data_Valid low; inputs are scrambled mid-frame.
    task automatic test_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                              input string name);
        build_frame(d, pe, pt);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (TX_OUT !== exp_q[i])
                $display("FAIL %s bit %0d: TX_OUT=%b expected %b", name, i, TX_OUT, exp_q[i]);
            else n_passed++;
            n_checks++;
            if (busy !== 1'b1)
                $display("FAIL %s busy %0d: busy=%b expected 1", name, i, busy);
            else n_passed++;
            P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
            @(negedge CLK);
        end
        n_checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s end: TX_OUT=%b busy=%b expected 1 0", name, TX_OUT, busy);
        else n_passed++;
    endtask

    task automatic test_directed();
        test_frame(8'hA5, 1'b0, 1'b0, "a5_nopar");
        test_frame(8'hA5, 1'b1, 1'b0, "a5_even");
        test_frame(8'hA5, 1'b1, 1'b1, "a5_odd");
        test_frame(8'h01, 1'b1, 1'b0, "01_even");
        test_frame(8'h01, 1'b1, 1'b1, "01_odd");
    endtask

    task automatic test_ignore_busy();
        build_frame(8'h3C, 1'b0, 1'b0);
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (TX_OUT !== exp_q[k] || busy !== 1'b1)
                $display("FAIL ignore bit %0d: TX_OUT=%b busy=%b expected %b 1",
                         k, TX_OUT, busy, exp_q[k]);
            else n_passed++;
            Data_Valid = (k == 3 || k == 7 || k == 9);
            if (k == 3) P_DATA = 8'hFF;
            if (k == 7) begin PAR_EN = 1'b1; P_DATA = DW'($urandom); end
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0)
                $display("FAIL ignore idle %0d: TX_OUT=%b busy=%b expected 1 0", j, TX_OUT, busy);
            else n_passed++;
            @(negedge CLK);
        end
        PAR_EN = 1'b0;
    endtask

    task automatic test_back_to_back();
        build_frame(8'h55, 1'b0, 1'b0);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (TX_OUT !== exp_q[k] || busy !== 1'b1)
                $display("FAIL b2b first %0d: TX_OUT=%b busy=%b expected %b 1",
                         k, TX_OUT, busy, exp_q[k]);
            else n_passed++;
            if (k == 2) begin P_DATA = 8'h0F; PAR_EN = 1'b1; PAR_TYP = 1'b1; end
            @(negedge CLK);
        end
        n_checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0)
            $display("FAIL b2b gap: TX_OUT=%b busy=%b expected 1 0", TX_OUT, busy);
        else n_passed++;
        build_frame(8'h0F, 1'b1, 1'b1);
        @(negedge CLK);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (TX_OUT !== exp_q[k] || busy !== 1'b1)
                $display("FAIL b2b second %0d: TX_OUT=%b busy=%b expected %b 1",
                         k, TX_OUT, busy, exp_q[k]);
            else n_passed++;
            if (k == 0) Data_Valid = 1'b0;
            @(negedge CLK);
        end
        n_checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0)
            $display("FAIL b2b end: TX_OUT=%b busy=%b expected 1 0", TX_OUT, busy);
        else n_passed++;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        build_frame(8'hA5, 1'b0, 1'b0);
        P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            n_checks++;
            if (TX_OUT !== exp_q[k] || busy !== 1'b1)
                $display("FAIL rst_mid bit %0d: TX_OUT=%b busy=%b expected %b 1",
                         k, TX_OUT, busy, exp_q[k]);
            else n_passed++;
            if (k == 5) begin RST = 1'b0; Data_Valid = 1'b1; end
            @(negedge CLK);
        end
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0)
                $display("FAIL rst_mid abort %0d: TX_OUT=%b busy=%b expected 1 0", j, TX_OUT, busy);
            else n_passed++;
            @(negedge CLK);
        end
        RST = 1'b1; Data_Valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_mid release: TX_OUT=%b busy=%b expected 1 0", TX_OUT, busy);
        else n_passed++;
        test_frame(8'hA5, 1'b1, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            int gap;
            test_frame(DW'($urandom), 1'($urandom), 1'($urandom), "random");
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                n_checks++;
                if (TX_OUT !== 1'b1 || busy !== 1'b0)
                    $display("FAIL random gap: TX_OUT=%b busy=%b expected 1 0", TX_OUT, busy);
                else n_passed++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter: data_width, default 8, payload bits per frame.
REQ-002 CLK  input  1  TX bit clock; one serial bit period per CLK cycle; all state on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-low; sampled on rising edge of CLK.
REQ-004 P_DATA  input  data_width  parallel payload, sampled only on an accepted request.
REQ-005 Data_Valid  input  1  transmit request, single-cycle or held.
REQ-006 PAR_EN  input  1  1 = insert parity bit after data; sampled with P_DATA.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd; sampled with P_DATA.
REQ-008 TX_OUT  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  high while a frame occupies the line, registered.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 Request SHALL be accepted only when Data_Valid=1 at a rising edge while state=IDLE; Data_Valid while not IDLE SHALL be ignored, with no queuing.
REQ-012 On acceptance the block SHALL latch P_DATA, PAR_EN and PAR_TYP into internal registers; input changes after acceptance SHALL NOT affect the frame.
REQ-013 Parity bit SHALL be computed from latched data: even = XOR of all data bits; odd = inverse of that XOR.
REQ-014 The cycle after the accepting edge: state=START, TX_OUT=0, busy=1 (zero-cycle input-to-output latency beyond the register).
REQ-015 START SHALL last exactly 1 cycle, then DATA.
REQ-016 DATA SHALL last exactly data_width cycles, driving latched bits LSB first (bit 0 first, bit data_width-1 last); the bit counter SHALL be sized ceil(log2(data_width+1)) and clear on entry to DATA.
REQ-017 After the last data bit: PARITY if latched PAR_EN=1, else STOP.
REQ-018 PARITY SHALL last 1 cycle with TX_OUT = parity bit, then STOP.
REQ-019 STOP SHALL last 1 cycle with TX_OUT=1, busy=1, then IDLE.
REQ-020 In IDLE, TX_OUT=1 and busy=0.
REQ-021 busy-high duration per frame SHALL be data_width+2 cycles (parity off) or data_width+3 cycles (parity on).
REQ-022 Data_Valid held high continuously SHALL produce back-to-back frames separated by exactly one IDLE cycle (TX_OUT=1, busy=0); the second frame carries P_DATA as sampled at its own acceptance edge.
REQ-023 Data_Valid high in the STOP cycle SHALL be ignored; acceptance occurs only from IDLE.
REQ-024 TX_OUT and busy SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-025 RST=0 at a rising edge SHALL force state=IDLE, TX_OUT=1, busy=0, bit counter=0, latched data/parity config=0, regardless of frame progress.
REQ-026 Reset mid-frame SHALL abort the frame with no further data/parity/stop bits driven; the line returns high the cycle after the reset edge.
REQ-027 Data_Valid during or on the same edge as RST=0 SHALL be ignored; the first acceptance requires RST=1 at that edge.

Verification
REQ-028 P_DATA=0xA5, PAR_EN=0, 1-cycle Data_Valid -> TX_OUT 0,1,0,1,0,0,1,0,1,1 then idle 1; busy high for exactly 10 cycles.
REQ-029 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-bit frame; repeat with PAR_TYP=1 -> parity bit 1.
REQ-030 P_DATA=0x01, PAR_EN=1, PAR_TYP=0 -> TX_OUT 0,1,0,0,0,0,0,0,0,1,1; PAR_TYP=1 -> parity 0.
REQ-031 Accept 0x3C, then pulse Data_Valid with P_DATA=0xFF and change P_DATA/PAR_EN at cycles 3 and 7 of the frame -> frame bits remain 0x3C, no second frame, busy falls after 10 cycles.
REQ-032 Data_Valid held high with P_DATA=0x55 then 0x0F at the second acceptance -> two frames, one idle-high cycle between, second frame data 0x0F.
REQ-033 RST=0 asserted at cycle 5 of a 0xA5 frame -> next cycle TX_OUT=1, busy=0; a new request after RST=1 produces a complete clean frame.
